// File: rtl/life_pkg.sv
// Shared types and defaults for the Life streaming pipeline.
// Holds board geometry defaults, the row type and the row buffer FSM states.
package life_pkg;

  localparam int ROW_LENGTH_DEF = 1280;
  localparam int NUM_ROWS_DEF   = 720;
  localparam int ROW_IDX_W      = $clog2(NUM_ROWS_DEF);

  typedef logic [ROW_LENGTH_DEF-1:0] row_t;

  typedef enum logic [1:0] {
    FILL0,
    FILL1,
    STREAM,
    FLUSH
  } state_t;

  typedef enum logic [1:0] {
    SRC_IN,
    SRC_ZERO,
    SRC_F0,
    SRC_F1
  } src_t;

endpackage

// File: rtl/row_window_buffer.sv
// Streaming three-row window buffer feeding the next-state array.
// Ports: clk, rst_n (sync, active low); row_in/row_in_valid/row_in_ready
// row input handshake; top_row/middle_row/bottom_row/row_index/win_valid/
// win_ready window output handshake. Macro ROW_WINDOW_WRAP_EN selects a
// toroidal board (rows wrap, window 0 emitted last) instead of zero padding.
module row_window_buffer #(
  parameter int ROW_LENGTH = life_pkg::ROW_LENGTH_DEF,
  parameter int NUM_ROWS   = life_pkg::NUM_ROWS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ROW_LENGTH-1:0]       row_in,
  input  logic                        row_in_valid,
  output logic                        row_in_ready,
  output logic [ROW_LENGTH-1:0]       top_row,
  output logic [ROW_LENGTH-1:0]       middle_row,
  output logic [ROW_LENGTH-1:0]       bottom_row,
  output logic [$clog2(NUM_ROWS)-1:0] row_index,
  output logic                        win_valid,
  input  logic                        win_ready
);
  import life_pkg::*;

  localparam int IW = $clog2(NUM_ROWS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ROWS - 1);
`ifdef ROW_WINDOW_WRAP_EN
  localparam logic [IW-1:0] IDX_PEN = IW'(NUM_ROWS - 2);
`endif

  state_t state;
  state_t state_nx;

  logic [ROW_LENGTH-1:0] prev_q;
  logic [ROW_LENGTH-1:0] cur_q;
  logic [ROW_LENGTH-1:0] nxt_q;
  logic [ROW_LENGTH-1:0] nxt_val;
`ifdef ROW_WINDOW_WRAP_EN
  logic [ROW_LENGTH-1:0] first0;
  logic [ROW_LENGTH-1:0] first1;
`endif

  logic [IW-1:0] in_cnt;
  logic [IW-1:0] out_cnt;
  logic [IW-1:0] idx_nx;
  logic          last_win;

  logic accept;
  logic consume;
  logic advance;
  logic shift;
  logic load0;
  logic present;
  logic mark_last;
  logic frame_done;
  src_t nxt_src;

  assign accept  = row_in_valid && row_in_ready;
  assign consume = win_valid && win_ready;
  // The window slot is free or being emptied this cycle.
  assign advance = !win_valid || win_ready;

  assign top_row    = prev_q;
  assign middle_row = cur_q;
  assign bottom_row = nxt_q;
  assign row_index  = out_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL0;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL0:
        if (accept) state_nx = FILL1;
      FILL1:
        if (accept) state_nx = (NUM_ROWS == 2) ? FLUSH : STREAM;
      STREAM:
        if (accept && in_cnt == IDX_LAST) state_nx = FLUSH;
      FLUSH:
        if (last_win && consume) state_nx = FILL0;
      default:
        state_nx = FILL0;
    endcase
  end

  always_comb begin
    row_in_ready = 1'b0;
    shift        = 1'b0;
    load0        = 1'b0;
    present      = 1'b0;
    mark_last    = 1'b0;
    frame_done   = 1'b0;
    nxt_src      = SRC_IN;
    idx_nx       = out_cnt;
    unique case (state)
      FILL0: begin
        row_in_ready = 1'b1;
        load0        = accept;
      end
      FILL1: begin
        row_in_ready = 1'b1;
        shift        = accept;
        idx_nx       = '0;
`ifndef ROW_WINDOW_WRAP_EN
        present      = accept;
`endif
      end
      STREAM: begin
        row_in_ready = advance;
        shift        = accept;
        present      = accept;
        // Accepting row k+1 completes window k.
        idx_nx       = in_cnt - IW'(1);
      end
      FLUSH: begin
        if (last_win) begin
          frame_done = consume;
        end else if (advance) begin
          shift   = 1'b1;
          present = 1'b1;
`ifdef ROW_WINDOW_WRAP_EN
          if (out_cnt == IDX_PEN) begin
            nxt_src = SRC_F0;
            idx_nx  = IDX_LAST;
          end else begin
            nxt_src   = SRC_F1;
            idx_nx    = '0;
            mark_last = 1'b1;
          end
`else
          nxt_src   = SRC_ZERO;
          idx_nx    = IDX_LAST;
          mark_last = 1'b1;
`endif
        end
      end
      default: begin
        row_in_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    nxt_val = row_in;
    case (nxt_src)
      SRC_ZERO: nxt_val = '0;
`ifdef ROW_WINDOW_WRAP_EN
      SRC_F0:   nxt_val = first0;
      SRC_F1:   nxt_val = first1;
`endif
      default:  nxt_val = row_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q    <= '0;
      cur_q     <= '0;
      nxt_q     <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      win_valid <= 1'b0;
      last_win  <= 1'b0;
`ifdef ROW_WINDOW_WRAP_EN
      first0    <= '0;
      first1    <= '0;
`endif
    end else begin
      // Row 0 clears older rows so nothing leaks across frames.
      if (load0) begin
        prev_q <= '0;
        cur_q  <= '0;
        nxt_q  <= row_in;
      end else if (shift) begin
        prev_q <= cur_q;
        cur_q  <= nxt_q;
        nxt_q  <= nxt_val;
      end
      if (accept) begin
        if (in_cnt == IDX_LAST) in_cnt <= '0;
        else                    in_cnt <= in_cnt + IW'(1);
      end
      if (present) begin
        win_valid <= 1'b1;
        out_cnt   <= idx_nx;
      end else if (consume) begin
        win_valid <= 1'b0;
      end
      if (mark_last) last_win <= 1'b1;
      if (frame_done) begin
        last_win <= 1'b0;
        out_cnt  <= '0;
        in_cnt   <= '0;
      end
`ifdef ROW_WINDOW_WRAP_EN
      if (accept && state == FILL0) first0 <= row_in;
      if (accept && state == FILL1) first1 <= row_in;
`endif
    end
  end

endmodule

// File: tb/tb_row_window_buffer.sv
// Self-checking bench for row_window_buffer (ROW_LENGTH=8, NUM_ROWS 4 and 2).
// Windows are predicted from the frame rows and compared in emission order.
module tb_row_window_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] row_in;
  logic       row_in_valid;
  logic       win_ready;

  logic       rdy4, wv4;
  logic [7:0] t4, m4, b4;
  logic [1:0] k4;
  logic       rdy2, wv2;
  logic [7:0] t2, m2, b2;
  logic [0:0] k2;

  row_window_buffer #(.ROW_LENGTH(8), .NUM_ROWS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .row_in(row_in), .row_in_valid(row_in_valid),
    .row_in_ready(rdy4),
    .top_row(t4), .middle_row(m4), .bottom_row(b4),
    .row_index(k4), .win_valid(wv4), .win_ready(win_ready)
  );

  row_window_buffer #(.ROW_LENGTH(8), .NUM_ROWS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .row_in(row_in), .row_in_valid(row_in_valid),
    .row_in_ready(rdy2),
    .top_row(t2), .middle_row(m2), .bottom_row(b2),
    .row_index(k2), .win_valid(wv2), .win_ready(win_ready)
  );

  logic       sel2;
  logic       m_rdy, m_wv;
  logic [7:0] m_t, m_m, m_b;
  int         m_k;

  always_comb begin
    m_rdy = sel2 ? rdy2 : rdy4;
    m_wv  = sel2 ? wv2  : wv4;
    m_t   = sel2 ? t2   : t4;
    m_m   = sel2 ? m2   : m4;
    m_b   = sel2 ? b2   : b4;
    m_k   = sel2 ? int'(k2) : int'(k4);
  end

  typedef struct {
    logic [7:0] t;
    logic [7:0] m;
    logic [7:0] b;
    int         k;
  } win_t;

  win_t       exp_q[$];
  logic [7:0] src_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference: window k is rows (k-1, k, k+1) of the frame.
  function automatic void add_frame(input logic [7:0] r[$]);
    int n;
    win_t w;
    n = r.size();
`ifdef ROW_WINDOW_WRAP_EN
    for (int j = 1; j <= n; j++) begin
      int k;
      k = j % n;
      w.t = r[(k + n - 1) % n];
      w.m = r[k];
      w.b = r[(k + 1) % n];
      w.k = k;
      exp_q.push_back(w);
    end
`else
    for (int k = 0; k < n; k++) begin
      w.t = (k > 0) ? r[k-1] : 8'h00;
      w.m = r[k];
      w.b = (k < n - 1) ? r[k+1] : 8'h00;
      w.k = k;
      exp_q.push_back(w);
    end
`endif
    foreach (r[i]) src_q.push_back(r[i]);
  endfunction

  function automatic void add_random_frame(input int n);
    logic [7:0] r[$];
    for (int i = 0; i < n; i++) r.push_back(8'($urandom));
    add_frame(r);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    row_in_valid = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int vpct, input int rpct,
                     input int stall_k, input bit chk_lat);
    int cyc = 0;
    int stall = 0;
    int acc = 0;
    int lat_row;
    int acc_cyc = -1;
    bit seen_v = 1'b0;
    bit in_stall;
    logic [7:0] st, sm, sb;
    int sk;
    win_t e;
`ifdef ROW_WINDOW_WRAP_EN
    lat_row = 2;
`else
    lat_row = 1;
`endif
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      row_in_valid = (src_q.size() > 0) && ($urandom_range(99) < vpct);
      row_in = row_in_valid ? src_q[0] : 8'($urandom);
      win_ready = ($urandom_range(99) < rpct);
      in_stall = 1'b0;
      if (stall_k >= 0 && m_wv && m_k == stall_k && stall < 5) begin
        if (stall == 0) begin
          st = m_t; sm = m_m; sb = m_b; sk = m_k;
        end
        win_ready = 1'b0;
        in_stall = 1'b1;
        stall++;
      end
      #1;
      if (in_stall) begin
        vectors++;
        if (m_rdy !== 1'b0 || m_t !== st || m_m !== sm ||
            m_b !== sb || m_k != sk) begin
          miscompares++;
          $display("FAIL stall_hold: got rdy=%b %h %h %h k%0d want rdy=0 %h %h %h k%0d",
                   m_rdy, m_t, m_m, m_b, m_k, st, sm, sb, sk);
        end
      end
      if (chk_lat && !seen_v && m_wv) begin
        seen_v = 1'b1;
        vectors++;
        if (acc_cyc < 0 || cyc != acc_cyc + 1) begin
          miscompares++;
          $display("FAIL latency: valid at cycle %0d, want %0d",
                   cyc, acc_cyc + 1);
        end
      end
      if (m_wv && win_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_window: got %h %h %h k%0d want none",
                   m_t, m_m, m_b, m_k);
        end else begin
          e = exp_q.pop_front();
          if (m_t !== e.t || m_m !== e.m || m_b !== e.b || m_k != e.k) begin
            miscompares++;
            $display("FAIL window: got %h %h %h k%0d want %h %h %h k%0d",
                     m_t, m_m, m_b, m_k, e.t, e.m, e.b, e.k);
          end
        end
      end
      if (row_in_valid && m_rdy) begin
        void'(src_q.pop_front());
        if (acc == lat_row) acc_cyc = cyc;
        acc++;
      end
      cyc++;
    end
    if (cyc >= 2000) begin
      miscompares++;
      $display("FAIL timeout: rows left %0d windows left %0d want 0 0",
               src_q.size(), exp_q.size());
      src_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    row_in_valid = 1'b0;
    win_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    #1;
    vectors++;
    if (m_wv !== 1'b0 || m_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_hs: got valid=%b ready=%b want 0 1",
               name, m_wv, m_rdy);
    end
  endtask

  task automatic test_reset();
    sel2 = 1'b0;
    do_reset();
    check_idle("reset");
    vectors++;
    if (m_t !== 8'h00 || m_m !== 8'h00 || m_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rows: got %h %h %h want 00 00 00",
               m_t, m_m, m_b);
    end
    vectors++;
    if (m_k != 0) begin
      miscompares++;
      $display("FAIL reset_index: got %0d want 0", m_k);
    end
  endtask

  task automatic test_stream();
    logic [7:0] r[$];
    r = '{8'h01, 8'h02, 8'h04, 8'h08};
    add_frame(r);
    run(100, 100, -1, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] r[$];
    r = '{8'h01, 8'h02, 8'h04, 8'h08};
    add_frame(r);
    run(100, 100, 1, 1'b0);
    check_idle("bp_end");
  endtask

  task automatic test_back_to_back();
    add_random_frame(4);
    add_random_frame(4);
    run(100, 100, -1, 1'b0);
  endtask

  task automatic test_random();
    repeat (4) add_random_frame(4);
    run(60, 55, -1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r[$];
    r = '{8'h01, 8'h02, 8'h04};
    foreach (r[i]) begin
      @(negedge clk);
      row_in_valid = 1'b1;
      row_in = r[i];
      win_ready = 1'b1;
    end
    @(negedge clk);
    row_in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midreset");
    vectors++;
    if (m_t !== 8'h00 || m_m !== 8'h00 || m_b !== 8'h00 || m_k != 0) begin
      miscompares++;
      $display("FAIL midreset_rows: got %h %h %h k%0d want 00 00 00 k0",
               m_t, m_m, m_b, m_k);
    end
    add_random_frame(4);
    run(80, 80, -1, 1'b0);
  endtask

  task automatic test_num_rows2();
    logic [7:0] r[$];
    sel2 = 1'b1;
    do_reset();
    r = '{8'hAA, 8'h55};
    add_frame(r);
    run(100, 100, -1, 1'b0);
    check_idle("n2_end");
    add_random_frame(2);
    add_random_frame(2);
    run(70, 70, -1, 1'b0);
    check_idle("n2_end2");
    sel2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    row_in = 8'h00;
    row_in_valid = 1'b0;
    win_ready = 1'b0;
    sel2 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_num_rows2();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
